// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A = load/store unit, B = debug/loader) arbiter onto a single data memory.
// Latency: 3 cycles from the IDLE cycle a request is sampled in to its ack (IDLE, SERVE, DONE); one access per 3 cycles.
// Backpressure: requests are sampled only in IDLE; a request held through SERVE/DONE simply waits, nothing is dropped.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   a_*/b_* req, we, addr, wdata   requester inputs, latched at grant
//   a_ack/b_ack, a_rdata/b_rdata   one-cycle completion pulse, registered read data per port
//   mem_*                          memory write strobe, addresses, write data, combinational read data
//   busy                           high whenever an access is in flight
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_flag_write,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              win_b_q, win_b_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              grant_b;

  // B wins when it is the only requester, or when A has been granted
  // STARVE_LIMIT times in a row while B was waiting.
  assign grant_b = b_req && (!a_req || (starve_cnt_q == LIMIT));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    win_b_d      = win_b_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d = SERVE;
          win_b_d = grant_b;
          if (grant_b) begin
            we_d         = b_we;
            addr_d       = b_addr;
            wdata_d      = b_wdata;
            starve_cnt_d = '0;
          end else begin
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            // Only count A wins that actually made B wait; saturate.
            if (b_req && (starve_cnt_q != LIMIT)) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      SERVE: begin
        state_d = DONE;
        // Read data is captured into the winner's register only.
        if (!we_q) begin
          if (win_b_q) begin
            b_rdata_d = mem_data_out;
          end else begin
            a_rdata_d = mem_data_out;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      win_b_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      win_b_q      <= win_b_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Memory-side outputs come straight from the latched access, so they hold
  // their last values through DONE and IDLE; only the strobe is state-gated.
  assign mem_flag_write = (state_q == SERVE) && we_q;
  assign mem_write_addr = addr_q;
  assign mem_read_addr  = addr_q;
  assign mem_data_in    = wdata_q;

  assign a_ack   = (state_q == DONE) && !win_b_q;
  assign b_ack   = (state_q == DONE) && win_b_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack, mem_flag_write, busy;
  logic [DW-1:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_write_addr, mem_read_addr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Memory seen by the DUT, and the reference copy owned by the model.
  logic [DW-1:0] env_mem [16];
  logic [DW-1:0] ref_mem [16];

  // Model: an access is either absent (age 0) or in its 1st/2nd cycle after grant.
  int            m_age = 0;
  int            m_starve = 0;
  bit            m_win_b = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_ra = '0;
  logic [DW-1:0] m_rb = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_flag_write(mem_flag_write), .mem_write_addr(mem_write_addr),
    .mem_read_addr(mem_read_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  assign mem_data_out = env_mem[mem_read_addr[5:2]];

  always @(posedge clk) begin
    if (mem_flag_write) env_mem[mem_write_addr[5:2]] <= mem_data_in;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per rising edge.
  always @(posedge clk) begin
    // A write strobe that was high this cycle reaches memory even if reset hits now.
    if (m_age == 1 && m_we) ref_mem[m_addr[5:2]] = m_wdata;
    if (!rst_n) begin
      m_age = 0; m_starve = 0; m_win_b = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_ra = '0; m_rb = '0;
    end else if (m_age == 0) begin
      if (a_req || b_req) begin
        m_win_b = b_req && (!a_req || m_starve == LIM);
        if (m_win_b) begin
          m_starve = 0; m_we = b_we; m_addr = b_addr; m_wdata = b_wdata;
        end else begin
          if (b_req && m_starve < LIM) m_starve++;
          m_we = a_we; m_addr = a_addr; m_wdata = a_wdata;
        end
        m_age = 1;
      end
    end else if (m_age == 1) begin
      if (!m_we) begin
        if (m_win_b) m_rb = ref_mem[m_addr[5:2]];
        else         m_ra = ref_mem[m_addr[5:2]];
      end
      m_age = 2;
    end else begin
      m_age = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_age != 0);
      chk("a_ack", a_ack, m_age == 2 && !m_win_b);
      chk("b_ack", b_ack, m_age == 2 && m_win_b);
      chk("one_ack", a_ack && b_ack, 0);
      chk("flag_write", mem_flag_write, m_age == 1 && m_we);
      chk("write_addr", mem_write_addr, m_addr);
      chk("read_addr", mem_read_addr, m_addr);
      chk("data_in", mem_data_in, m_wdata);
      chk("a_rdata", a_rdata, m_ra);
      chk("b_rdata", b_rdata, m_rb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    bit exp_order [10];
    bit got_order [$];
    logic [DW-1:0] w;

    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      env_mem[i] = w;
      ref_mem[i] = w;
    end
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    tick();
    chk_en = 1;
    tick();
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_acks", {a_ack, b_ack, mem_flag_write}, 0);
    chk("rst_outs", {a_rdata, b_rdata}, 0);
    rst_n = 1;
    tick();

    // Read of address 8 by A.
    env_mem[2] = 32'h21101122;
    ref_mem[2] = 32'h21101122;
    a_req = 1; a_we = 0; a_addr = 8;
    tick(); a_req = 0;
    tick(); smp();
    chk("rd8_ack", {a_ack, b_ack}, 2'b10);
    chk("rd8_data", a_rdata, 32'h21101122);
    chk("rd8_b_unchanged", b_rdata, 0);
    tick();

    // B writes 40, then A reads it back.
    b_req = 1; b_we = 1; b_addr = 40; b_wdata = 32'hDEADBEEF;
    tick(); b_req = 0; smp();
    chk("wr40_strobe", mem_flag_write, 1);
    chk("wr40_addr", mem_write_addr, 40);
    tick(); smp();
    chk("wr40_strobe_off", mem_flag_write, 0);
    chk("wr40_ack", b_ack, 1);
    tick();
    a_req = 1; a_we = 0; a_addr = 40;
    tick(); a_req = 0;
    tick(); smp();
    chk("rd40_data", a_rdata, 32'hDEADBEEF);
    tick();

    // Both requesting continuously: starvation pattern.
    a_req = 1; a_we = 0; a_addr = 4;
    b_req = 1; b_we = 0; b_addr = 12;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (a_ack) got_order.push_back(1'b0);
      if (b_ack) got_order.push_back(1'b1);
      tick();
    end
    a_req = 0; b_req = 0;
    chk("order_len", got_order.size(), 10);
    for (int i = 0; i < 10 && i < got_order.size(); i++)
      chk($sformatf("order_%0d", i), got_order[i], exp_order[i]);
    tick(); tick();

    // Simultaneous rise: A first, B three cycles later.
    a_req = 1; b_req = 1;
    tick(); tick(); smp();
    chk("sim_a_ack", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    tick(); tick(); tick(); smp();
    chk("sim_b_ack", {a_ack, b_ack}, 2'b01);
    b_req = 0;
    tick();

    // Inputs change during SERVE: memory keeps the latched values.
    a_req = 1; a_we = 1; a_addr = 12; a_wdata = 32'h11112222;
    tick(); a_addr = 20; a_wdata = 32'h33334444; a_req = 0; smp();
    chk("latch_addr", mem_write_addr, 12);
    chk("latch_data", mem_data_in, 32'h11112222);
    tick(); tick();

    // Reset in the SERVE cycle of a write.
    b_req = 1; b_we = 1; b_addr = 16; b_wdata = 32'h55;
    tick(); smp();
    rst_n = 0; b_req = 0;
    tick(); smp();
    chk("abort_outs", {a_ack, b_ack, mem_flag_write, busy}, 0);
    chk("abort_addr", {mem_write_addr, mem_data_in}, 0);
    rst_n = 1;
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
      a_addr = AW'($urandom_range(0, 15) * 4); a_wdata = $urandom;
      b_req = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1);
      b_addr = AW'($urandom_range(0, 15) * 4); b_wdata = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1; a_req = 0; b_req = 0;
    tick(); tick(); tick(); tick();
    smp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
